// File: rtl/rank_pipe_ctrl.sv
// rank_pipe_ctrl: front-end controller for the shared round-robin rank unit.
// Round-robin arbitration of NUM_PORTS insert requesters onto the unit's
// single insert interface, a three-state dequeue sequencer, and an optional
// out-of-range flow ID dropper enabled by defining RANK_PIPE_CTRL_DROP_EN.
//
// Handshake semantics: a transfer happens on a rising clk edge when valid and
// ready are both high in that cycle; ready never waits on a future valid, and
// a valid, once raised, is the requester's promise to hold its payload until
// it is accepted.
module rank_pipe_ctrl #(
    parameter int NUM_PORTS     = 4,
    parameter int FLOW_ID_WIDTH = 16,
    parameter int MAX_NUM_FLOWS = 4,
    parameter int RANK_WIDTH    = 16,
    parameter int META_WIDTH    = 16,
    localparam int LG_W         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_PORTS-1:0]               in_valid,
    output logic [NUM_PORTS-1:0]               in_ready,
    input  logic [NUM_PORTS*FLOW_ID_WIDTH-1:0] in_flowID,
    input  logic [NUM_PORTS*META_WIDTH-1:0]    in_meta,
    output logic                               rank_insert,
    output logic [FLOW_ID_WIDTH-1:0]           rank_flowID,
    output logic [META_WIDTH-1:0]              rank_meta,
    input  logic                               rank_nearly_full,
    input  logic                               rank_valid,
    input  logic [RANK_WIDTH-1:0]              rank_in,
    input  logic [META_WIDTH-1:0]              rank_meta_in,
    output logic                               rank_remove,
    input  logic                               deq_req,
    output logic                               deq_valid,
    input  logic                               deq_ready,
    output logic [RANK_WIDTH-1:0]              deq_rank,
    output logic [META_WIDTH-1:0]              deq_meta,
    output logic [31:0]                        drop_cnt,
    output logic [1:0]                         dbg_deq_state,
    output logic [LG_W-1:0]                    dbg_last_grant
);

    typedef enum logic [1:0] {
        DEQ_IDLE = 2'd0,
        DEQ_WAIT = 2'd1,
        DEQ_HOLD = 2'd2
    } deq_state_t;

    localparam logic [LG_W-1:0] LAST_PORT = LG_W'(NUM_PORTS - 1);

    // ---------------- insert path state ----------------
    logic [LG_W-1:0]          last_grant_q, last_grant_d;
    logic                     rank_insert_q, rank_insert_d;
    logic [FLOW_ID_WIDTH-1:0] rank_flowID_q, rank_flowID_d;
    logic [META_WIDTH-1:0]    rank_meta_q, rank_meta_d;

    logic                     grant_found;
    logic [LG_W-1:0]          grant_idx;
    logic [LG_W-1:0]          cand_idx;
    logic                     transfer;
    logic [FLOW_ID_WIDTH-1:0] sel_flowID;
    logic [META_WIDTH-1:0]    sel_meta;

    // Round-robin search starting one past the last grant; ready is withheld
    // during reset and whenever the rank unit signals nearly-full.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant_q;
        cand_idx    = '0;
        in_ready    = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand_idx = LG_W'((int'(last_grant_q) + i) % NUM_PORTS);
            if (!grant_found && in_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
        if (rst_n && !rank_nearly_full && grant_found) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign transfer   = |(in_valid & in_ready);
    assign sel_flowID = in_flowID[int'(grant_idx)*FLOW_ID_WIDTH +: FLOW_ID_WIDTH];
    assign sel_meta   = in_meta[int'(grant_idx)*META_WIDTH +: META_WIDTH];

`ifdef RANK_PIPE_CTRL_DROP_EN
    localparam logic [FLOW_ID_WIDTH-1:0] MAX_FLOWS_W = FLOW_ID_WIDTH'(MAX_NUM_FLOWS);

    logic [31:0] drop_cnt_q, drop_cnt_d;

    // Capture the granted payload; out-of-range flows are counted instead of
    // being forwarded, and the counter sticks at its maximum.
    always_comb begin
        last_grant_d  = last_grant_q;
        rank_insert_d = 1'b0;
        rank_flowID_d = rank_flowID_q;
        rank_meta_d   = rank_meta_q;
        drop_cnt_d    = drop_cnt_q;
        if (transfer) begin
            last_grant_d  = grant_idx;
            rank_flowID_d = sel_flowID;
            rank_meta_d   = sel_meta;
            if (sel_flowID >= MAX_FLOWS_W) begin
                if (drop_cnt_q != 32'hFFFF_FFFF) begin
                    drop_cnt_d = drop_cnt_q + 32'd1;
                end
            end else begin
                rank_insert_d = 1'b1;
            end
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    // Capture the granted payload; every transfer is forwarded unchanged.
    always_comb begin
        last_grant_d  = last_grant_q;
        rank_insert_d = 1'b0;
        rank_flowID_d = rank_flowID_q;
        rank_meta_d   = rank_meta_q;
        if (transfer) begin
            last_grant_d  = grant_idx;
            rank_flowID_d = sel_flowID;
            rank_meta_d   = sel_meta;
            rank_insert_d = 1'b1;
        end
    end

    assign drop_cnt = 32'd0;
`endif

    // Insert-side registers; reset cancels any pending insert strobe and
    // points the arbiter so port 0 is searched first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q  <= LAST_PORT;
            rank_insert_q <= 1'b0;
            rank_flowID_q <= '0;
            rank_meta_q   <= '0;
        end else begin
            last_grant_q  <= last_grant_d;
            rank_insert_q <= rank_insert_d;
            rank_flowID_q <= rank_flowID_d;
            rank_meta_q   <= rank_meta_d;
        end
    end

    assign rank_insert    = rank_insert_q;
    assign rank_flowID    = rank_flowID_q;
    assign rank_meta      = rank_meta_q;
    assign dbg_last_grant = last_grant_q;

    // ---------------- dequeue path ----------------
    deq_state_t            deq_state_q;
    logic [RANK_WIDTH-1:0] deq_rank_q;
    logic [META_WIDTH-1:0] deq_meta_q;

    // Dequeue sequencer: wait for a head entry, pop it once, hold it for the
    // consumer. Requests arriving outside IDLE are simply not looked at.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deq_state_q <= DEQ_IDLE;
            deq_rank_q  <= '0;
            deq_meta_q  <= '0;
        end else begin
            case (deq_state_q)
                DEQ_IDLE: begin
                    if (deq_req) begin
                        deq_state_q <= DEQ_WAIT;
                    end
                end
                DEQ_WAIT: begin
                    if (rank_valid) begin
                        deq_rank_q  <= rank_in;
                        deq_meta_q  <= rank_meta_in;
                        deq_state_q <= DEQ_HOLD;
                    end
                end
                DEQ_HOLD: begin
                    if (deq_ready) begin
                        deq_state_q <= DEQ_IDLE;
                    end
                end
                default: deq_state_q <= DEQ_IDLE;
            endcase
        end
    end

    // The pop strobe coincides with the capture cycle so the unit advances
    // its head exactly when the entry is taken.
    assign rank_remove   = (deq_state_q == DEQ_WAIT) && rank_valid;
    assign deq_valid     = (deq_state_q == DEQ_HOLD);
    assign deq_rank      = deq_rank_q;
    assign deq_meta      = deq_meta_q;
    assign dbg_deq_state = deq_state_q;

endmodule

// File: tb/tb_rank_pipe_ctrl.sv
// Directed self-checking bench for rank_pipe_ctrl (4 ports, 16-bit fields).
module tb_rank_pipe_ctrl;

  localparam int NP = 4;
  localparam int FW = 16;
  localparam int MW = 16;
  localparam int RW = 16;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     in_valid;
  logic [NP-1:0]     in_ready;
  logic [NP*FW-1:0]  in_flowID;
  logic [NP*MW-1:0]  in_meta;
  logic              rank_insert;
  logic [FW-1:0]     rank_flowID;
  logic [MW-1:0]     rank_meta;
  logic              rank_nearly_full;
  logic              rank_valid;
  logic [RW-1:0]     rank_in;
  logic [MW-1:0]     rank_meta_in;
  logic              rank_remove;
  logic              deq_req;
  logic              deq_valid;
  logic              deq_ready;
  logic [RW-1:0]     deq_rank;
  logic [MW-1:0]     deq_meta;
  logic [31:0]       drop_cnt;
  logic [1:0]        dbg_deq_state;
  logic [1:0]        dbg_last_grant;

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  rank_pipe_ctrl #(
    .NUM_PORTS(NP), .FLOW_ID_WIDTH(FW), .MAX_NUM_FLOWS(4),
    .RANK_WIDTH(RW), .META_WIDTH(MW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_flowID(in_flowID), .in_meta(in_meta),
    .rank_insert(rank_insert), .rank_flowID(rank_flowID), .rank_meta(rank_meta),
    .rank_nearly_full(rank_nearly_full), .rank_valid(rank_valid),
    .rank_in(rank_in), .rank_meta_in(rank_meta_in), .rank_remove(rank_remove),
    .deq_req(deq_req), .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_rank(deq_rank), .deq_meta(deq_meta), .drop_cnt(drop_cnt),
    .dbg_deq_state(dbg_deq_state), .dbg_last_grant(dbg_last_grant)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_port(input int p, input logic [FW-1:0] f, input logic [MW-1:0] m);
    in_flowID[p*FW +: FW] = f;
    in_meta[p*MW +: MW]   = m;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = '0;
    in_flowID = '0;
    in_meta = '0;
    rank_nearly_full = 1'b0;
    rank_valid = 1'b0;
    rank_in = '0;
    rank_meta_in = '0;
    deq_req = 1'b0;
    deq_ready = 1'b0;
    for (int p = 0; p < NP; p++) set_port(p, FW'(p), MW'(16'h00A0 + p));

    // ---------------- reset state ----------------
    step();
    step();
    in_valid = 4'hF;
    settle();
    check("rst_in_ready_forced", in_ready, 4'h0);
    step();
    check("rst_rank_insert", rank_insert, 0);
    check("rst_rank_flowID", rank_flowID, 0);
    check("rst_rank_meta", rank_meta, 0);
    check("rst_deq_valid", deq_valid, 0);
    check("rst_rank_remove", rank_remove, 0);
    check("rst_deq_rank", deq_rank, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_state", dbg_deq_state, ST_IDLE);
    check("rst_last_grant", dbg_last_grant, 3);

    // ---------------- round-robin fairness ----------------
    rst_n = 1'b1;
    settle();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rr_ready_%0d", k), in_ready, 4'b0001 << (k % 4));
      step();
      check($sformatf("rr_insert_%0d", k), rank_insert, 1);
      check($sformatf("rr_flow_%0d", k), rank_flowID, k % 4);
      check($sformatf("rr_meta_%0d", k), rank_meta, 16'h00A0 + (k % 4));
    end
    in_valid = '0;
    step();
    check("rr_idle_insert", rank_insert, 0);
    check("rr_idle_flow_hold", rank_flowID, 3);

    // ---------------- backpressure ----------------
    in_valid = 4'b1010;
    settle();
    check("bp_first_ready", in_ready, 4'b0010);
    step();
    check("bp_first_insert", rank_insert, 1);
    check("bp_first_flow", rank_flowID, 1);
    rank_nearly_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("bp_ready_low_%0d", k), in_ready, 4'b0000);
      step();
      check($sformatf("bp_no_insert_%0d", k), rank_insert, 0);
    end
    rank_nearly_full = 1'b0;
    settle();
    check("bp_release_ready", in_ready, 4'b1000);
    step();
    check("bp_release_insert", rank_insert, 1);
    check("bp_release_flow", rank_flowID, 3);
    in_valid = '0;
    step();

    // ---------------- dequeue on empty unit ----------------
    deq_req = 1'b1;
    step();
    deq_req = 1'b0;
    check("deq_to_wait", dbg_deq_state, ST_WAIT);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("deq_empty_remove_%0d", k), rank_remove, 0);
      check($sformatf("deq_empty_valid_%0d", k), deq_valid, 0);
      step();
    end
    rank_valid = 1'b1;
    rank_in = 16'h0007;
    rank_meta_in = 16'h0055;
    settle();
    check("deq_remove_pulse", rank_remove, 1);
    step();
    check("deq_hold_valid", deq_valid, 1);
    check("deq_hold_rank", deq_rank, 16'h0007);
    check("deq_hold_meta", deq_meta, 16'h0055);
    check("deq_hold_no_remove", rank_remove, 0);

    // ---------------- ignored request while holding ----------------
    deq_req = 1'b1;
    rank_in = 16'h0099;
    step();
    deq_req = 1'b0;
    check("ign_state_hold", dbg_deq_state, ST_HOLD);
    check("ign_no_remove", rank_remove, 0);
    check("ign_rank_kept", deq_rank, 16'h0007);
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    check("ign_back_idle", dbg_deq_state, ST_IDLE);
    check("ign_valid_low", deq_valid, 0);
    check("ign_idle_no_remove", rank_remove, 0);
    rank_valid = 1'b0;

    // ---------------- out-of-range flow ID ----------------
    set_port(2, 16'd5, 16'h0BEE);
    in_valid = 4'b0100;
    settle();
    check("drop_ready", in_ready, 4'b0100);
    step();
    in_valid = '0;
`ifdef RANK_PIPE_CTRL_DROP_EN
    check("drop_no_insert", rank_insert, 0);
    check("drop_cnt_one", drop_cnt, 1);
`else
    check("fwd_insert", rank_insert, 1);
    check("fwd_flow", rank_flowID, 5);
    check("fwd_drop_cnt", drop_cnt, 0);
`endif
    check("drop_ptr_advanced", dbg_last_grant, 2);
    set_port(2, 16'd2, 16'h00A2);
    step();

    // ---------------- reset mid-HOLD ----------------
    deq_req = 1'b1;
    rank_valid = 1'b1;
    rank_in = 16'h0009;
    step();
    deq_req = 1'b0;
    step();
    rank_valid = 1'b0;
    check("mr_hold_valid", deq_valid, 1);
    check("mr_hold_rank", deq_rank, 16'h0009);
    in_valid = 4'b0010;
    step();
    check("mr_pending_insert", rank_insert, 1);
    rst_n = 1'b0;
    settle();
    check("mr_ready_forced", in_ready, 4'b0000);
    step();
    check("mr_deq_valid", deq_valid, 0);
    check("mr_insert_cancel", rank_insert, 0);
    check("mr_state", dbg_deq_state, ST_IDLE);
    check("mr_deq_rank", deq_rank, 0);
    rst_n = 1'b1;
    in_valid = 4'hF;
    settle();
    check("mr_first_grant", in_ready, 4'b0001);
    step();
    in_valid = '0;
    check("mr_first_insert", rank_insert, 1);
    check("mr_first_flow", rank_flowID, 0);
    step();

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
